ibuf: RTL

- Instruction buffer between the fetch unit and decode.
- Accepts 0-2 fetched instructions per cycle, each with PC, predecode prediction and fetch exception info.
- Holds them in a circular FIFO and presents up to 2 oldest entries per cycle to decode.
- Decouples icache/fetch latency from decode stalls; a pipeline flush empties it.

---
 rtl/ibuf.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/ibuf.sv
// Instruction buffer: circular FIFO between fetch and decode, 0-2 in / 0-2 out per cycle.
// Optional macro IBUF_PERF_CNT_EN enables empty/full cycle performance counters.
module ibuf #(
  parameter int DEPTH   = 16,
  parameter int RESERVE = 4,
  parameter int EXCP_W  = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  output logic              i_ready,
  input  logic [1:0]        i_size,
  input  logic [31:0]       i_pc0,
  input  logic [31:0]       i_pc1,
  input  logic [31:0]       i_inst0,
  input  logic [31:0]       i_inst1,
  input  logic              i_pred_taken0,
  input  logic              i_pred_taken1,
  input  logic [31:0]       i_pred_target0,
  input  logic [31:0]       i_pred_target1,
  input  logic              i_have_excp,
  input  logic [EXCP_W-1:0] i_excp_type,
  output logic              o_valid0,
  output logic              o_valid1,
  output logic [31:0]       o_pc0,
  output logic [31:0]       o_pc1,
  output logic [31:0]       o_inst0,
  output logic [31:0]       o_inst1,
  output logic              o_pred_taken0,
  output logic              o_pred_taken1,
  output logic [31:0]       o_pred_target0,
  output logic [31:0]       o_pred_target1,
  output logic              o_have_excp0,
  output logic              o_have_excp1,
  output logic [EXCP_W-1:0] o_excp_type0,
  output logic [EXCP_W-1:0] o_excp_type1,
  input  logic [1:0]        o_accept,
  output logic [31:0]       perf_empty_cycles,
  output logic [31:0]       perf_full_cycles
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW:0] DEPTH_W   = (CW+1)'(DEPTH);
  localparam logic [CW:0] RESERVE_W = (CW+1)'(RESERVE);

  typedef struct packed {
    logic [31:0]       pc;
    logic [31:0]       inst;
    logic              pred_taken;
    logic [31:0]       pred_target;
    logic              have_excp;
    logic [EXCP_W-1:0] excp_type;
  } entry_t;

  entry_t          mem_q [DEPTH];
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic [1:0]      push_s;
  logic [CW-1:0]   pop_s;
  logic [CW:0]     sum_s;
  logic            wr0_en_s, wr1_en_s;
  logic [PW-1:0]   wr_idx1_s, rd_idx1_s;
  entry_t          wr_ent0_s, wr_ent1_s, rd_ent0_s, rd_ent1_s;

  // Next-state for pointers and occupancy; flush wipes everything and blocks writes.
  always_comb begin
    push_s   = (i_size == 2'd3) ? 2'd0 : i_size;
    pop_s    = ({{(CW-2){1'b0}}, o_accept} > count_q) ? count_q : {{(CW-2){1'b0}}, o_accept};
    sum_s    = {1'b0, count_q} - {1'b0, pop_s} + {{(CW-1){1'b0}}, push_s};
    rd_ptr_d = rd_ptr_q + pop_s[PW-1:0];
    wr_ptr_d = wr_ptr_q + {{(PW-2){1'b0}}, push_s};
    wr0_en_s = 1'b0;
    wr1_en_s = 1'b0;
    // Overflow cannot happen under the reserve rule; saturate anyway.
    if (sum_s > DEPTH_W) begin
      count_d = DEPTH_W[CW-1:0];
    end else begin
      count_d = sum_s[CW-1:0];
    end
    if (flush) begin
      rd_ptr_d = {PW{1'b0}};
      wr_ptr_d = {PW{1'b0}};
      count_d  = {CW{1'b0}};
    end else begin
      wr0_en_s = (push_s != 2'd0);
      wr1_en_s = (push_s == 2'd2);
    end
  end

  always_comb begin
    wr_idx1_s = wr_ptr_q + {{(PW-1){1'b0}}, 1'b1};
    rd_idx1_s = rd_ptr_q + {{(PW-1){1'b0}}, 1'b1};
    wr_ent0_s = '{pc: i_pc0, inst: i_inst0, pred_taken: i_pred_taken0,
                  pred_target: i_pred_target0, have_excp: i_have_excp,
                  excp_type: i_excp_type};
    wr_ent1_s = '{pc: i_pc1, inst: i_inst1, pred_taken: i_pred_taken1,
                  pred_target: i_pred_target1, have_excp: 1'b0,
                  excp_type: {EXCP_W{1'b0}}};
    rd_ent0_s = mem_q[rd_ptr_q];
    rd_ent1_s = mem_q[rd_idx1_s];
  end

  // Pointer and count registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr_q <= {PW{1'b0}};
      wr_ptr_q <= {PW{1'b0}};
      count_q  <= {CW{1'b0}};
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage, deliberately not reset.
  always_ff @(posedge clk) begin
    if (wr0_en_s) begin
      mem_q[wr_ptr_q] <= wr_ent0_s;
    end
    if (wr1_en_s) begin
      mem_q[wr_idx1_s] <= wr_ent1_s;
    end
  end

  assign i_ready        = (DEPTH_W - {1'b0, count_q}) >= RESERVE_W;
  assign o_valid0       = !flush && (count_q >= CW'(1));
  assign o_valid1       = !flush && (count_q >= CW'(2));
  assign o_pc0          = rd_ent0_s.pc;
  assign o_pc1          = rd_ent1_s.pc;
  assign o_inst0        = rd_ent0_s.inst;
  assign o_inst1        = rd_ent1_s.inst;
  assign o_pred_taken0  = rd_ent0_s.pred_taken;
  assign o_pred_taken1  = rd_ent1_s.pred_taken;
  assign o_pred_target0 = rd_ent0_s.pred_target;
  assign o_pred_target1 = rd_ent1_s.pred_target;
  assign o_have_excp0   = rd_ent0_s.have_excp;
  assign o_have_excp1   = rd_ent1_s.have_excp;
  assign o_excp_type0   = rd_ent0_s.excp_type;
  assign o_excp_type1   = rd_ent1_s.excp_type;

`ifdef IBUF_PERF_CNT_EN
  logic [31:0] perf_empty_q, perf_empty_d;
  logic [31:0] perf_full_q, perf_full_d;

  always_comb begin
    perf_empty_d = perf_empty_q;
    perf_full_d  = perf_full_q;
    if (!flush) begin
      if (count_q == {CW{1'b0}}) begin
        perf_empty_d = perf_empty_q + 32'd1;
      end else begin
        perf_empty_d = perf_empty_q;
      end
      if (!i_ready) begin
        perf_full_d = perf_full_q + 32'd1;
      end else begin
        perf_full_d = perf_full_q;
      end
    end else begin
      perf_empty_d = perf_empty_q;
      perf_full_d  = perf_full_q;
    end
  end

  // Performance counter registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_empty_q <= 32'd0;
      perf_full_q  <= 32'd0;
    end else begin
      perf_empty_q <= perf_empty_d;
      perf_full_q  <= perf_full_d;
    end
  end

  assign perf_empty_cycles = perf_empty_q;
  assign perf_full_cycles  = perf_full_q;
`else
  assign perf_empty_cycles = 32'd0;
  assign perf_full_cycles  = 32'd0;
`endif

endmodule
